// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address: byte writes to rx_data_o, byte reads from tx_data_i.
// Define I2C_TARGET_CLOCK_STRETCH_EN to hold SCL low on reads until tx_valid_i supplies data.
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h30
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   inout  wire        sda_io,
   inout  wire        scl_io,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic [7:0] tx_data_i,
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   input  logic       tx_valid_i,
`endif
   output logic       tx_ready_o,
   output logic       rw_o,
   output logic       start_o,
   output logic       stop_o,
   output logic       nak_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
   } state_t;

   state_t     r_state;
   logic       r_sda_s1, r_sda_s2, r_sda_h;
   logic       r_scl_s1, r_scl_s2, r_scl_h;
   logic [3:0] r_bitcnt;
   logic [6:0] r_shift;
   logic [6:0] r_tx_shift;
   logic       r_sda_oe;
   logic [7:0] r_rx_data;
   logic       r_rx_valid, r_tx_ready, r_rw, r_start, r_stop, r_nak;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   logic       r_wait_tx;
   logic       r_scl_oe;
`endif

   logic w_scl_rise, w_scl_fall, w_start, w_stop, w_load_tx;

   assign w_scl_rise = r_scl_s2 & ~r_scl_h;
   assign w_scl_fall = ~r_scl_s2 & r_scl_h;
   assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
   // The falling edge that closes an ACK clock hands the bus over to the first read bit.
   assign w_load_tx  = w_scl_fall &
                       (((r_state == S_ADDR_ACK) & r_sda_oe & r_rw) | (r_state == S_READ_ACK));

   // Gating with reset releases SDA in the very cycle reset is applied.
   assign sda_io = (r_sda_oe & reset_ni) ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   assign scl_io = (r_scl_oe & reset_ni) ? 1'b0 : 1'bz;
`else
   assign scl_io = 1'bz;
`endif

   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_valid;
   assign tx_ready_o = r_tx_ready;
   assign rw_o       = r_rw;
   assign start_o    = r_start;
   assign stop_o     = r_stop;
   assign nak_o      = r_nak;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_sda_s1   <= 1'b1;
         r_sda_s2   <= 1'b1;
         r_sda_h    <= 1'b1;
         r_scl_s1   <= 1'b1;
         r_scl_s2   <= 1'b1;
         r_scl_h    <= 1'b1;
         r_state    <= S_IDLE;
         r_bitcnt   <= 4'd0;
         r_sda_oe   <= 1'b0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b0;
         r_rw       <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_nak      <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         r_wait_tx  <= 1'b0;
         r_scl_oe   <= 1'b0;
`endif
      end else begin
         r_sda_s1   <= sda_io;
         r_sda_s2   <= r_sda_s1;
         r_sda_h    <= r_sda_s2;
         r_scl_s1   <= scl_io;
         r_scl_s2   <= r_scl_s1;
         r_scl_h    <= r_scl_s2;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b0;
         r_start    <= 1'b0;
         r_stop     <= 1'b0;
         r_nak      <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         r_scl_oe   <= r_wait_tx;
`endif
         if (w_stop) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
            r_stop   <= 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            r_wait_tx <= 1'b0;
            r_scl_oe  <= 1'b0;
`endif
         end else if (w_start) begin
            r_state  <= S_ADDR;
            r_bitcnt <= 4'd0;
            r_sda_oe <= 1'b0;
            r_start  <= 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            r_wait_tx <= 1'b0;
            r_scl_oe  <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_ADDR: if (w_scl_rise) begin
                  r_shift  <= {r_shift[5:0], r_sda_s2};
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     if (r_shift == ADDR) begin
                        r_rw    <= r_sda_s2;
                        r_state <= S_ADDR_ACK;
                     end else begin
                        r_state <= S_WAIT_STOP;
                     end
                  end
               end
               S_ADDR_ACK: if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     r_sda_oe <= 1'b1;
                  end else if (!r_rw) begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= 4'd0;
                     r_state  <= S_WRITE;
                  end
               end
               S_WRITE: if (w_scl_rise) begin
                  r_shift  <= {r_shift[5:0], r_sda_s2};
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     r_rx_data  <= {r_shift, r_sda_s2};
                     r_rx_valid <= 1'b1;
                     r_state    <= S_WRITE_ACK;
                  end
               end
               S_WRITE_ACK: if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     r_sda_oe <= 1'b1;
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= 4'd0;
                     r_state  <= S_WRITE;
                  end
               end
               S_READ: begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                  if (r_wait_tx) begin
                     if (tx_valid_i) begin
                        r_tx_shift <= tx_data_i[6:0];
                        r_sda_oe   <= ~tx_data_i[7];
                        r_wait_tx  <= 1'b0;
                     end
                  end else
`endif
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_READ_ACK;
                     end else begin
                        r_sda_oe   <= ~r_tx_shift[6];
                        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                     end
                  end
               end
               S_READ_ACK: if (w_scl_rise && r_sda_s2) begin
                  r_nak   <= 1'b1;
                  r_state <= S_WAIT_STOP;
               end
               default: ;
            endcase
            if (w_load_tx) begin
               r_state    <= S_READ;
               r_bitcnt   <= 4'd0;
               r_tx_ready <= 1'b1;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
               r_sda_oe   <= 1'b0;
               r_wait_tx  <= 1'b1;
`else
               r_tx_shift <= tx_data_i[6:0];
               r_sda_oe   <= ~tx_data_i[7];
`endif
            end
         end
      end
   end

endmodule
